// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU operation codes and default datapath widths.
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_NOT = 4'd6;
  localparam logic [3:0] ALU_CMP = 4'd7;
  localparam logic [3:0] ALU_MOV = 4'd8;
  localparam logic [3:0] ALU_JMP = 4'd9;
  localparam logic [3:0] ALU_JC  = 4'd10;
  localparam logic [3:0] ALU_JZ  = 4'd11;

  function automatic logic is_jump(input logic [3:0] code);
    return (code == ALU_JMP) || (code == ALU_JC) || (code == ALU_JZ);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: computes the result, carry/borrow, zero, and which flags the
// operation is allowed to update.
module alu_core
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              c_upd,
  output logic              z_upd
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // The extra top bit of the widened difference is the borrow (unsigned a < b).
  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    c_upd  = 1'b0;
    z_upd  = 1'b0;
    case (alu_ctrl)
      ALU_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
        c_upd  = 1'b1;
        z_upd  = 1'b1;
      end
      ALU_SUB, ALU_CMP: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
        c_upd  = 1'b1;
        z_upd  = 1'b1;
      end
      ALU_AND: begin result = op_a & op_b; z_upd = 1'b1; end
      ALU_OR:  begin result = op_a | op_b; z_upd = 1'b1; end
      ALU_XOR: begin result = op_a ^ op_b; z_upd = 1'b1; end
      ALU_NOT: begin result = ~op_a;       z_upd = 1'b1; end
      ALU_MOV: begin result = op_b;        z_upd = 1'b1; end
      default: begin result = '0; end
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, architectural C/Z flags, jump resolution and the EX/MEM latch.
module ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_AW-1:0] rd,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] branch_target,
  input  logic              stall,
  input  logic              flush,
  output logic              exmem_valid,
  output logic [DATA_W-1:0] exmem_result,
  output logic [DATA_W-1:0] exmem_store_data,
  output logic [REG_AW-1:0] exmem_rd,
  output logic              exmem_reg_write,
  output logic              exmem_mem_read,
  output logic              exmem_mem_write,
  output logic              flag_c,
  output logic              flag_z,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_pc
);

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;
  logic              c_upd;
  logic              z_upd;

  logic              advance;
  logic              jump_op;
  logic              jump_cond;
  logic              taken;
  logic [DATA_W-1:0] next_result;
  logic              next_reg_write;
  logic              next_mem_read;
  logic              next_mem_write;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .result   (alu_result),
    .carry    (alu_carry),
    .zero     (alu_zero),
    .c_upd    (c_upd),
    .z_upd    (z_upd)
  );

  // Conditional jumps read the registered flags, which already reflect the previous advanced instruction.
  always_comb begin
    advance   = in_valid & ~stall & ~flush;
    jump_op   = is_jump(alu_ctrl);
    jump_cond = 1'b0;
    case (alu_ctrl)
      ALU_JMP: jump_cond = 1'b1;
      ALU_JC:  jump_cond = flag_c;
      ALU_JZ:  jump_cond = flag_z;
      default: jump_cond = 1'b0;
    endcase
    taken          = advance & jump_cond;
    next_result    = jump_op ? branch_target : alu_result;
    next_reg_write = reg_write & in_valid & ~jump_op & (alu_ctrl != ALU_CMP)
                     & (alu_ctrl[3:2] != 2'b11);
    next_mem_read  = mem_read & in_valid & ~jump_op;
    next_mem_write = mem_write & in_valid & ~jump_op;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (advance) begin
      if (c_upd) flag_c <= alu_carry;
      if (z_upd) flag_z <= alu_zero;
    end
  end

  // Stall holds everything except the redirect pulse, which must never last more than one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_valid      <= 1'b0;
      exmem_result     <= '0;
      exmem_store_data <= '0;
      exmem_rd         <= '0;
      exmem_reg_write  <= 1'b0;
      exmem_mem_read   <= 1'b0;
      exmem_mem_write  <= 1'b0;
      branch_taken     <= 1'b0;
      branch_pc        <= '0;
    end else if (stall) begin
      branch_taken <= 1'b0;
    end else if (flush) begin
      exmem_valid      <= 1'b0;
      exmem_result     <= '0;
      exmem_store_data <= '0;
      exmem_rd         <= '0;
      exmem_reg_write  <= 1'b0;
      exmem_mem_read   <= 1'b0;
      exmem_mem_write  <= 1'b0;
      branch_taken     <= 1'b0;
      branch_pc        <= '0;
    end else begin
      exmem_valid      <= in_valid;
      exmem_result     <= next_result;
      exmem_store_data <= store_data;
      exmem_rd         <= rd;
      exmem_reg_write  <= next_reg_write;
      exmem_mem_read   <= next_mem_read;
      exmem_mem_write  <= next_mem_write;
      branch_taken     <= taken;
      branch_pc        <= taken ? branch_target : '0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: a reference model pushes expected latch contents
// into a scoreboard queue as each instruction is driven; they are popped after the edge.
module tb_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        c;
    logic        z;
    logic        bt;
    logic [31:0] bpc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] branch_target;
  logic        stall;
  logic        flush;
  logic        exmem_valid;
  logic [31:0] exmem_result;
  logic [31:0] exmem_store_data;
  logic [4:0]  exmem_rd;
  logic        exmem_reg_write;
  logic        exmem_mem_read;
  logic        exmem_mem_write;
  logic        flag_c;
  logic        flag_z;
  logic        branch_taken;
  logic [31:0] branch_pc;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb_q[$];
  exp_t model;
  logic model_c;
  logic model_z;

  ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .alu_ctrl         (alu_ctrl),
    .op_a             (op_a),
    .op_b             (op_b),
    .store_data       (store_data),
    .rd               (rd),
    .reg_write        (reg_write),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .branch_target    (branch_target),
    .stall            (stall),
    .flush            (flush),
    .exmem_valid      (exmem_valid),
    .exmem_result     (exmem_result),
    .exmem_store_data (exmem_store_data),
    .exmem_rd         (exmem_rd),
    .exmem_reg_write  (exmem_reg_write),
    .exmem_mem_read   (exmem_mem_read),
    .exmem_mem_write  (exmem_mem_write),
    .flag_c           (flag_c),
    .flag_z           (flag_z),
    .branch_taken     (branch_taken),
    .branch_pc        (branch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one instruction at the falling edge and predicts the latch after the next rising edge.
  task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] sd, input logic [4:0] r, input logic rw,
                               input logic mr, input logic mw, input logic [31:0] tgt,
                               input logic v, input logic st, input logic fl);
    logic [32:0] w;
    logic [31:0] res;
    logic        cu, zu, cv, jmp, cond, adv;
    @(negedge clk);
    alu_ctrl = ctrl; op_a = a; op_b = b; store_data = sd; rd = r;
    reg_write = rw; mem_read = mr; mem_write = mw; branch_target = tgt;
    in_valid = v; stall = st; flush = fl;
    res = '0; cu = 1'b0; zu = 1'b0; cv = 1'b0; jmp = 1'b0; cond = 1'b0;
    case (ctrl)
      4'd1: begin w = {1'b0, a} + {1'b0, b}; res = w[31:0]; cv = w[32]; cu = 1'b1; zu = 1'b1; end
      4'd2, 4'd7: begin res = a - b; cv = (a < b); cu = 1'b1; zu = 1'b1; end
      4'd3: begin res = a & b; zu = 1'b1; end
      4'd4: begin res = a | b; zu = 1'b1; end
      4'd5: begin res = a ^ b; zu = 1'b1; end
      4'd6: begin res = ~a;    zu = 1'b1; end
      4'd8: begin res = b;     zu = 1'b1; end
      4'd9:  begin jmp = 1'b1; cond = 1'b1; end
      4'd10: begin jmp = 1'b1; cond = model_c; end
      4'd11: begin jmp = 1'b1; cond = model_z; end
      default: res = '0;
    endcase
    adv = v && !st && !fl;
    if (st) begin
      model.bt = 1'b0;
    end else if (fl) begin
      model = '0;
    end else begin
      model.valid  = v;
      model.result = jmp ? tgt : res;
      model.store  = sd;
      model.rd     = r;
      model.rw     = v && rw && !jmp && (ctrl != 4'd7) && (ctrl < 4'd12);
      model.mr     = v && mr && !jmp;
      model.mw     = v && mw && !jmp;
      model.bt     = adv && cond;
      model.bpc    = (adv && cond) ? tgt : 32'h0;
    end
    if (adv && cu) model_c = cv;
    if (adv && zu) model_z = (res == 32'h0);
    model.c = model_c;
    model.z = model_z;
    sb_q.push_back(model);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL %s.scoreboard: observed empty queue, expected an entry", tag);
      return;
    end
    tests_run--;
    e = sb_q.pop_front();
    cmp({tag, ".valid"},  32'(exmem_valid),      32'(e.valid));
    cmp({tag, ".result"}, exmem_result,          e.result);
    cmp({tag, ".store"},  exmem_store_data,      e.store);
    cmp({tag, ".rd"},     32'(exmem_rd),         32'(e.rd));
    cmp({tag, ".rw"},     32'(exmem_reg_write),  32'(e.rw));
    cmp({tag, ".mr"},     32'(exmem_mem_read),   32'(e.mr));
    cmp({tag, ".mw"},     32'(exmem_mem_write),  32'(e.mw));
    cmp({tag, ".c"},      32'(flag_c),           32'(e.c));
    cmp({tag, ".z"},      32'(flag_z),           32'(e.z));
    cmp({tag, ".bt"},     32'(branch_taken),     32'(e.bt));
    cmp({tag, ".bpc"},    branch_pc,             e.bpc);
  endtask

  task automatic checkAllZero(input string tag);
    cmp({tag, ".valid"},  32'(exmem_valid),     32'h0);
    cmp({tag, ".result"}, exmem_result,         32'h0);
    cmp({tag, ".store"},  exmem_store_data,     32'h0);
    cmp({tag, ".rd"},     32'(exmem_rd),        32'h0);
    cmp({tag, ".rw"},     32'(exmem_reg_write), 32'h0);
    cmp({tag, ".mr"},     32'(exmem_mem_read),  32'h0);
    cmp({tag, ".mw"},     32'(exmem_mem_write), 32'h0);
    cmp({tag, ".c"},      32'(flag_c),          32'h0);
    cmp({tag, ".z"},      32'(flag_z),          32'h0);
    cmp({tag, ".bt"},     32'(branch_taken),    32'h0);
    cmp({tag, ".bpc"},    branch_pc,            32'h0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; alu_ctrl = 4'd0; op_a = '0; op_b = '0;
    store_data = '0; rd = '0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    branch_target = '0; stall = 1'b0; flush = 1'b0;
    model = '0; model_c = 1'b0; model_z = 1'b0;
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ctrl, a, b, store, rd, rw, mr, mw, target, valid, stall, flush
    applyStimulus(4'd1, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd3, 1, 0, 0, 32'h0, 1, 0, 0);
    checkOutput("add_carry");
    applyStimulus(4'd10, 32'h0, 32'h0, 32'h0, 5'd0, 1, 1, 1, 32'h40, 1, 0, 0);
    checkOutput("jc_taken");
    applyStimulus(4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("bubble_after_jc");
    applyStimulus(4'd7, 32'd5, 32'd7, 32'h0, 5'd4, 1, 0, 0, 32'h0, 1, 0, 0);
    checkOutput("cmp_5_7");
    applyStimulus(4'd11, 32'h0, 32'h0, 32'h0, 5'd6, 1, 1, 1, 32'h80, 1, 0, 0);
    checkOutput("jz_not_taken");
    applyStimulus(4'd1, 32'hFFFF_FFFF, 32'h2, 32'h0, 5'd5, 1, 0, 0, 32'h0, 1, 0, 0);
    checkOutput("add_carry_nz");
    applyStimulus(4'd4, 32'h0, 32'h0, 32'h0, 5'd7, 1, 0, 0, 32'h0, 1, 0, 0);
    checkOutput("or_zero_keeps_c");
    applyStimulus(4'd9, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h1234, 1, 0, 0);
    checkOutput("jmp");
    applyStimulus(4'd2, 32'd10, 32'd3, 32'h0, 5'd8, 1, 0, 0, 32'h0, 1, 1, 0);
    checkOutput("sub_stall1");
    applyStimulus(4'd2, 32'd10, 32'd3, 32'h0, 5'd8, 1, 0, 0, 32'h0, 1, 1, 0);
    checkOutput("sub_stall2");
    applyStimulus(4'd2, 32'd10, 32'd3, 32'h0, 5'd8, 1, 0, 0, 32'h0, 1, 0, 0);
    checkOutput("sub_release");
    applyStimulus(4'd9, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h200, 1, 0, 1);
    checkOutput("jmp_flushed");
    applyStimulus(4'd1, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd2, 1, 0, 0, 32'h0, 1, 1, 1);
    checkOutput("stall_and_flush");
    applyStimulus(4'd5, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h0, 5'd9, 1, 0, 0, 32'h0, 1, 0, 0);
    checkOutput("xor");
    applyStimulus(4'd6, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd10, 1, 0, 0, 32'h0, 1, 0, 0);
    checkOutput("not_zero");
    applyStimulus(4'd8, 32'h0, 32'hCAFE_0001, 32'hDEAD_BEEF, 5'd11, 0, 0, 1, 32'h0, 1, 0, 0);
    checkOutput("mov_store");
    applyStimulus(4'd3, 32'hF0F0_0F0F, 32'h0FF0_0FF0, 32'h0, 5'd12, 1, 1, 0, 32'h0, 1, 0, 0);
    checkOutput("and_load");
    applyStimulus(4'd13, 32'h5, 32'h5, 32'h0, 5'd13, 1, 0, 0, 32'h0, 1, 0, 0);
    checkOutput("undefined_code");
    applyStimulus(4'd7, 32'd4, 32'd4, 32'h0, 5'd14, 1, 0, 0, 32'h0, 1, 0, 0);
    checkOutput("cmp_equal");
    applyStimulus(4'd11, 32'h0, 32'h0, 32'h0, 5'd0, 1, 0, 0, 32'h300, 1, 0, 0);
    checkOutput("jz_taken");
    applyStimulus(4'd1, 32'd100, 32'd23, 32'h0, 5'd15, 1, 0, 0, 32'h0, 1, 0, 0);
    checkOutput("add_plain");

    // Asynchronous reset away from any clock edge must clear state at once.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    model = '0; model_c = 1'b0; model_z = 1'b0;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'd2, 32'd1, 32'd2, 32'h0, 5'd1, 1, 0, 0, 32'h0, 1, 0, 0);
    checkOutput("sub_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage pipeline. Consumes the 4-bit ALU control code produced by the ALU control decoder, together with ID/EX operands and control bits, and performs the arithmetic or logic operation. Maintains the architectural carry and zero flags and resolves JMP/JC/JZ. Registers everything into the EX/MEM pipeline latch that feeds the memory stage.

## Interface
- `DATA_W`, default 32: operand, result and PC width.
- `REG_AW`, default 5: destination register address width.

- `clk`, input, 1: pipeline clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: the ID/EX latch holds a real instruction.
- `alu_ctrl`, input, 4: operation code.
- `op_a`, input, DATA_W: first operand, already forwarded.
- `op_b`, input, DATA_W: second operand, already register/immediate-muxed.
- `store_data`, input, DATA_W: store value for SW.
- `rd`, input, REG_AW: destination register.
- `reg_write`, input, 1: ID/EX control bit.
- `mem_read`, input, 1: ID/EX control bit.
- `mem_write`, input, 1: ID/EX control bit.
- `branch_target`, input, DATA_W: jump destination computed in ID.
- `stall`, input, 1: hold the EX/MEM latch and the instruction in EX.
- `flush`, input, 1: kill the instruction currently in EX.
- `exmem_valid`, output, 1: EX/MEM latch holds a real instruction.
- `exmem_result`, output, DATA_W: registered ALU result.
- `exmem_store_data`, output, DATA_W: registered store value.
- `exmem_rd`, output, REG_AW: registered destination register.
- `exmem_reg_write`, output, 1: registered control bit.
- `exmem_mem_read`, output, 1: registered control bit.
- `exmem_mem_write`, output, 1: registered control bit.
- `flag_c`, output, 1: architectural carry flag.
- `flag_z`, output, 1: architectural zero flag.
- `branch_taken`, output, 1: registered single-cycle redirect pulse.
- `branch_pc`, output, DATA_W: registered redirect address.

## Operation
- The instruction **advances** when `in_valid & !stall & !flush`. Only an advancing instruction updates the flags or raises a branch.
- Codes and results (all widths are DATA_W; carry is bit DATA_W of the (DATA_W+1)-bit sum):
  - 0 NOP: result 0.
  - 1 ADD: a+b. C = carry out.
  - 2 SUB: a−b. C = borrow, i.e. unsigned a<b.
  - 3 AND, 4 OR, 5 XOR: bitwise.
  - 6 NOT: ~a.
  - 7 CMP: computes a−b and sets C and Z as SUB does. `exmem_reg_write` is forced to 0.
  - 8 MOV: b.
  - 9 JMP: always taken.
  - 10 JC: taken if `flag_c`.
  - 11 JZ: taken if `flag_z`.
  - 12–15: treated as NOP with `reg_write` forced to 0.
- Flag updates:
  - ADD, SUB, CMP update both C and Z.
  - AND, OR, XOR, NOT, MOV update Z only; C is held.
  - NOP, jumps and undefined codes leave both flags unchanged.
  - Z = (result == 0).
- Jump resolution:
  - JC and JZ read the registered flags. Those flags already include the immediately preceding advanced instruction, so no flag forwarding is needed.
  - Jumps force `exmem_reg_write`, `exmem_mem_read` and `exmem_mem_write` to 0.
  - For a jump, `exmem_result` carries `branch_target`.
- EX/MEM latch update priority:
  - `stall` set: hold all latch outputs and flags; `branch_taken` is 0.
  - Else `flush` set: load a bubble. `exmem_valid` and all control bits are 0; data fields are don't-care but driven 0.
  - Else: load the computed values, with `exmem_valid = in_valid`.
- Reset (asynchronous, `rst_n` low): all outputs and flags go to 0. A reset mid-instruction discards that instruction.

## Timing
- Latency is 1 cycle: the operands present at edge N appear on `exmem_*` after edge N. Flags are visible after the same edge.
- `branch_taken` and `branch_pc` are registered with the latch.
  - The pulse is exactly one cycle high, even if a stall follows; the pulse clears on the next edge.
  - Upstream must flush the two younger instructions.
- Back-to-back operation: CMP at cycle N followed by JZ at N+1 uses CMP's Z.
- Simultaneous `stall` and `flush`: `stall` wins for the latch. The instruction in EX is still suppressed, so no flag update and no branch.

## Structure
- Shared package `pipe_pkg` holds:
  - ALU code constants (`ALU_NOP` … `ALU_JZ`, values 0–11).
  - `DATA_W` and `REG_AW` defaults.
- Sub-module `alu_core` is purely combinational: inputs `alu_ctrl`, `op_a`, `op_b`; outputs `result`, `carry`, `zero`, `c_upd`, `z_upd`.
- `ex_stage` holds the flag register, the branch decision and the EX/MEM latch.

## Test plan
- Reset low, then high: every output is 0; `flag_c` and `flag_z` are 0.
- ADD 0xFFFFFFFF + 0x00000001 → `exmem_result` 0, C=1, Z=1. A following JC with target 0x40 → `branch_taken` pulses for 1 cycle with `branch_pc` 0x40.
- CMP 5,7 → C=1, Z=0, `exmem_reg_write` 0. A following JZ → not taken, `exmem_valid` 1, all control bits 0.
- OR after ADD with carry: operands 0,0 → Z=1 and C remains 1.
- SUB with `stall` held for 2 cycles → latch and flags unchanged, no branch. When `stall` is released, the result appears on the next edge.
- JMP with `flush`=1 → no branch, `exmem_valid` 0. Assert `rst_n` low mid-stream → outputs clear immediately, asynchronously.
